// File: rtl/pixel_fb_pkg.sv
// pixel_fb_pkg: framebuffer geometry, bus widths and fill FSM encoding shared by
// the CPU-side fill engine and future GPU-side blocks.
package pixel_fb_pkg;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 17;
  localparam int COLOR_W   = 8;
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fill_state_t;
endpackage

// File: rtl/pixel_rect_fill_if.sv
// pixel_rect_fill_if: command handshake plus framebuffer write port of the fill
// engine; abort is present only when RECT_FILL_ABORT_EN is defined.
interface pixel_rect_fill_if;
  import pixel_fb_pkg::*;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [8:0]         cmd_x;
  logic [7:0]         cmd_y;
  logic [8:0]         cmd_w;
  logic [7:0]         cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               px_full;
  logic [ADDR_W-1:0]  px_addr;
  logic [COLOR_W-1:0] px_data;
  logic               px_we;
  logic               busy;
  logic               done;
`ifdef RECT_FILL_ABORT_EN
  logic               abort;
`endif
  modport master(
`ifdef RECT_FILL_ABORT_EN
    output abort,
`endif
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, px_full,
    input  cmd_ready, px_addr, px_data, px_we, busy, done
  );
  modport slave(
`ifdef RECT_FILL_ABORT_EN
    input  abort,
`endif
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, px_full,
    output cmd_ready, px_addr, px_data, px_we, busy, done
  );
endinterface

// File: rtl/pixel_rect_clip.sv
// pixel_rect_clip: clips a rectangle to the framebuffer and gives its first
// pixel address; y*FB_WIDTH is built from shifts (256+64).
module pixel_rect_clip
  import pixel_fb_pkg::*;
(
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic [8:0]        w,
  input  logic [7:0]        h,
  output logic [9:0]        x_end,
  output logic [9:0]        y_end,
  output logic              empty,
  output logic [ADDR_W-1:0] start_addr
);
  logic [9:0] x_sum, y_sum;
  always_comb begin
    x_sum      = {1'b0, x} + {1'b0, w};
    y_sum      = {2'b0, y} + {2'b0, h};
    x_end      = x_sum > 10'(FB_WIDTH) ? 10'(FB_WIDTH) : x_sum;
    y_end      = y_sum > 10'(FB_HEIGHT) ? 10'(FB_HEIGHT) : y_sum;
    empty      = w == 9'd0 || h == 8'd0 || x >= 9'(FB_WIDTH) || y >= 8'(FB_HEIGHT);
    start_addr = (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
  end
endmodule

// File: rtl/pixel_rect_fill.sv
// pixel_rect_fill: clipped rectangle fill engine, one framebuffer write per cycle
// with px_full backpressure; optional abort input under RECT_FILL_ABORT_EN.
module pixel_rect_fill
  import pixel_fb_pkg::*;
(
  input logic              clk50,
  input logic              reset_n,
  pixel_rect_fill_if.slave bus
);
  fill_state_t        state;
  logic [8:0]         x, w;
  logic [7:0]         y, h;
  logic [COLOR_W-1:0] color;
  logic [9:0]         x_end, y_end, col, row, clip_x_end, clip_y_end;
  logic [ADDR_W-1:0]  cur_addr, row_base, clip_addr;
  logic               clip_empty, abort_req, col_last, row_last;
  logic               cmd_ready, busy, done;
  pixel_rect_clip clip (
    .x(x), .y(y), .w(w), .h(h),
    .x_end(clip_x_end), .y_end(clip_y_end), .empty(clip_empty), .start_addr(clip_addr)
  );
`ifdef RECT_FILL_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif
  assign col_last      = col == x_end - 10'd1;
  assign row_last      = row == y_end - 10'd1;
  assign bus.px_we     = state == FILL && !bus.px_full;
  assign bus.px_addr   = cur_addr;
  assign bus.px_data   = color;
  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      {x, w, y, h, color} <= '0;
      {x_end, y_end, col, row} <= '0;
      cur_addr  <= '0;
      row_base  <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          {x, y, w, h, color} <= {bus.cmd_x, bus.cmd_y, bus.cmd_w, bus.cmd_h, bus.cmd_color};
          state     <= SETUP;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
        end
        SETUP: begin
          x_end    <= clip_x_end;
          y_end    <= clip_y_end;
          row_base <= clip_addr - ADDR_W'(x);
          cur_addr <= clip_addr;
          col      <= {1'b0, x};
          row      <= {2'b0, y};
          state    <= clip_empty || abort_req ? DONE : FILL;
          done     <= clip_empty || abort_req;
        end
        FILL: begin
          // the final pixel leaves the counters untouched so px_addr stays in range
          if (bus.px_we && !col_last) begin
            col      <= col + 10'd1;
            cur_addr <= cur_addr + ADDR_W'(1);
          end else if (bus.px_we && !row_last) begin
            row      <= row + 10'd1;
            row_base <= row_base + ADDR_W'(FB_WIDTH);
            cur_addr <= row_base + ADDR_W'(FB_WIDTH) + ADDR_W'(x);
            col      <= {1'b0, x};
          end
          if ((bus.px_we && col_last && row_last) || abort_req) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_rect_fill.sv
// tb_pixel_rect_fill: directed and random rectangle fills checked against a
// pixel-list model; covers RECT_FILL_ABORT_EN when that macro is defined.
module tb_pixel_rect_fill;
  import pixel_fb_pkg::*;
  logic clk50 = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, first_we = 0, done_cyc = 0, done_cnt = 0, full_viol = 0;
  int bp_mode = 0;
  int got_a[$];
  int got_d[$];
  int exp_a[$];
  pixel_rect_fill_if bus();
  pixel_rect_fill dut (.clk50(clk50), .reset_n(reset_n), .bus(bus));
  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;
  always @(negedge clk50) begin
    if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
    if (bus.px_we) begin
      if (bus.px_full) full_viol++;
      if (got_a.size() == 0) first_we = cyc;
      got_a.push_back(int'(bus.px_addr));
      got_d.push_back(int'(bus.px_data));
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  initial begin : bp_gen
    int k;
    k = 0;
    bus.px_full = 1'b0;
    forever begin
      @(posedge clk50);
      #1;
      bus.px_full = bp_mode == 1 ? (k % 5) < 3 : bp_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      k++;
    end
  end
  task automatic tick();
    @(posedge clk50);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic build(input int x, input int y, input int w, input int h);
    int xe, ye;
    xe = x + w < FB_WIDTH ? x + w : FB_WIDTH;
    ye = y + h < FB_HEIGHT ? y + h : FB_HEIGHT;
    exp_a.delete();
    for (int r = y; r < ye; r++)
      for (int c = x; c < xe; c++) exp_a.push_back(r * FB_WIDTH + c);
  endtask
  task automatic start(input int x, input int y, input int w, input int h, input int c);
    int n;
    n = 0;
    got_a.delete();
    got_d.delete();
    done_cnt = 0;
    full_viol = 0;
    build(x, y, w, h);
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    bus.cmd_x = 9'(x);
    bus.cmd_y = 8'(y);
    bus.cmd_w = 9'(w);
    bus.cmd_h = 8'(h);
    bus.cmd_color = 8'(c);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic finish_run(input string tag, input int c);
    int n, bad;
    n = 0;
    bad = 0;
    while (done_cnt == 0 && n < 90000) begin
      tick();
      n++;
    end
    check({tag, "_ready_after"}, bus.cmd_ready, 1);
    check({tag, "_busy_after"}, bus.busy, 0);
    tick();
    tick();
    check({tag, "_writes"}, got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      if (got_a[i] != exp_a[i] || got_d[i] != (c & 8'hFF)) bad++;
    check({tag, "_addr_data_bad"}, bad, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_we_while_full"}, full_viol, 0);
    if (bp_mode == 0) begin
      if (exp_a.size() > 0) check({tag, "_first_we_lat"}, first_we - acc_cyc, 2);
      check({tag, "_done_lat"}, done_cyc - acc_cyc, exp_a.size() + 2);
    end
  endtask
  initial begin : main
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_w = '0;
    bus.cmd_h = '0;
    bus.cmd_color = '0;
`ifdef RECT_FILL_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) tick();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_px_we", bus.px_we, 0);
    check("rst_px_addr", bus.px_addr, 0);
    check("rst_px_data", bus.px_data, 0);
    reset_n = 1'b1;
    tick();
    start(0, 0, 320, 240, 8'hE3);
    finish_run("full", 8'hE3);
    check("full_last_addr", got_a.size() > 0 ? got_a[got_a.size() - 1] : -1, FB_PIXELS - 1);
    start(300, 230, 40, 20, 8'h1C);
    finish_run("clip", 8'h1C);
    check("clip_first_addr", got_a.size() > 0 ? got_a[0] : -1, 73900);
    check("clip_row2_addr", got_a.size() > 20 ? got_a[20] : -1, 74220);
    check("clip_last_addr", got_a.size() > 0 ? got_a[got_a.size() - 1] : -1, 76799);
    start(5, 5, 0, 3, 8'h01);
    finish_run("empty_w", 8'h01);
    start(5, 5, 3, 0, 8'h02);
    finish_run("empty_h", 8'h02);
    start(320, 5, 3, 3, 8'h03);
    finish_run("empty_x", 8'h03);
    start(5, 240, 3, 3, 8'h04);
    finish_run("empty_y", 8'h04);
    bp_mode = 1;
    start(10, 5, 4, 2, 8'hA5);
    finish_run("bp32", 8'hA5);
    bp_mode = 0;
    start(100, 50, 16, 4, 8'h5A);
    tick();
    tick();
    check("poke_busy", bus.busy, 1);
    check("poke_ready", bus.cmd_ready, 0);
    bus.cmd_x = 9'd0;
    bus.cmd_y = 8'd0;
    bus.cmd_w = 9'd5;
    bus.cmd_h = 8'd5;
    bus.cmd_color = 8'h11;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    finish_run("poke", 8'h5A);
    start(0, 0, 50, 50, 8'h77);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.cmd_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_we", bus.px_we, 0);
    check("mid_rst_addr", bus.px_addr, 0);
    check("mid_rst_data", bus.px_data, 0);
    n = got_a.size();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_ready", bus.cmd_ready, 1);
    check("post_rst_no_writes", got_a.size(), n);
`ifdef RECT_FILL_ABORT_EN
    start(0, 0, 10, 10, 8'h3C);
    n = 0;
    while (got_a.size() < 4 && n < 100) begin
      tick();
      n++;
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    exp_a = exp_a[0:4];
    finish_run("abort", 8'h3C);
`endif
    for (int t = 0; t < 10; t++) begin
      bp_mode = int'($urandom_range(0, 2));
      start(int'($urandom_range(0, 330)), int'($urandom_range(0, 250)),
            int'($urandom_range(0, 24)), int'($urandom_range(0, 16)), int'($urandom_range(0, 255)));
      finish_run($sformatf("rand%0d", t), int'(bus.cmd_color));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
